// File: rtl/axi4l_sramx32_if.sv
// rtl/axi4l_sramx32_if.sv - AXI4-Lite types package and bus interface for the SRAM slave
package axi4l_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
endpackage

interface axi4l_if;
    import axi4l_pkg::*;

    logic  aclk;
    logic  aresetn;

    addr_t awaddr;
    logic  awvalid;
    logic  awready;

    data_t wdata;
    strb_t wstrb;
    logic  wvalid;
    logic  wready;

    resp_t bresp;
    logic  bvalid;
    logic  bready;

    addr_t araddr;
    logic  arvalid;
    logic  arready;

    data_t rdata;
    resp_t rresp;
    logic  rvalid;
    logic  rready;

    modport master (
        input  aclk, aresetn,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  aclk, aresetn,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4l_sramx32.sv
// rtl/axi4l_sramx32.sv - AXI4-Lite 32-bit SRAM slave; AXI4L_SRAM_OUTREG_EN adds a registered read stage
module dpramx32 #(
    parameter int WORD_AW = 10
) (
    input  logic               clk,
    input  logic [3:0]         we,
    input  logic [WORD_AW-1:0] waddr,
    input  logic [31:0]        wdata,
    input  logic               re,
    input  logic [WORD_AW-1:0] raddr,
    output logic [31:0]        q
);
    logic [31:0] mem [0:(1<<WORD_AW)-1];

    // byte-masked write port
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // registered read port; sees the pre-write word on a same-cycle collision
    always_ff @(posedge clk) begin
        if (re) begin
            q <= mem[raddr];
        end
    end
endmodule

module axi4l_sramx32 #(
    parameter int size = 'h1000
) (
    axi4l_if.slave axi
);
    import axi4l_pkg::*;

    localparam int BYTE_AW = $clog2(size);
    localparam int WORD_AW = BYTE_AW - 2;

    // ---------------- write path ----------------
    logic  aw_full;
    addr_t aw_addr_q;
    logic  w_full;
    data_t w_data_q;
    strb_t w_strb_q;
    logic  b_valid_q;
    resp_t b_resp_q;

    logic  aw_hs, w_hs, have_aw, have_w, commit;
    addr_t wr_addr;
    data_t wr_data;
    strb_t wr_strb;
    logic  wr_ok;

    assign axi.awready = !aw_full;
    assign axi.wready  = !w_full;
    assign axi.bvalid  = b_valid_q;
    assign axi.bresp   = b_resp_q;

    assign aw_hs   = axi.awvalid && !aw_full;
    assign w_hs    = axi.wvalid && !w_full;
    assign have_aw = aw_full || axi.awvalid;
    assign have_w  = w_full || axi.wvalid;
    assign commit  = have_aw && have_w && (!b_valid_q || axi.bready);

    // buffered entries take priority: a full buffer blocks its own channel
    assign wr_addr = aw_full ? aw_addr_q : axi.awaddr;
    assign wr_data = w_full ? w_data_q : axi.wdata;
    assign wr_strb = w_full ? w_strb_q : axi.wstrb;
    assign wr_ok   = (wr_addr >> BYTE_AW) == '0;

    // AW buffer: fill on handshake unless the commit consumes it the same cycle
    always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
        if (!axi.aresetn) begin
            aw_full   <= 1'b0;
            aw_addr_q <= '0;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= axi.awaddr;
            end
            aw_full <= commit ? 1'b0 : (aw_full || aw_hs);
        end
    end

    // W buffer: same fill/drain rule as AW
    always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
        if (!axi.aresetn) begin
            w_full   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            if (w_hs) begin
                w_data_q <= axi.wdata;
                w_strb_q <= axi.wstrb;
            end
            w_full <= commit ? 1'b0 : (w_full || w_hs);
        end
    end

    // B slot: loaded by a commit, released by bready
    always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
        if (!axi.aresetn) begin
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
        end else if (commit) begin
            b_valid_q <= 1'b1;
            b_resp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (axi.bready) begin
            b_valid_q <= 1'b0;
        end
    end

    // ---------------- read path ----------------
    logic  ar_ready, ar_hs, rd_ok;
    data_t ram_q;
    strb_t ram_we;

    assign axi.arready = ar_ready;
    assign ar_hs       = axi.arvalid && ar_ready;
    assign rd_ok       = (axi.araddr >> BYTE_AW) == '0;
    assign ram_we      = (commit && wr_ok) ? wr_strb : 4'b0000;

    dpramx32 #(.WORD_AW(WORD_AW)) u_ram (
        .clk   (axi.aclk),
        .we    (ram_we),
        .waddr (wr_addr[BYTE_AW-1:2]),
        .wdata (wr_data),
        .re    (ar_hs),
        .raddr (axi.araddr[BYTE_AW-1:2]),
        .q     (ram_q)
    );

    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr[1:0], axi.araddr[1:0]};

`ifdef AXI4L_SRAM_OUTREG_EN
    logic  s1_valid, s1_err, r_valid_q, advance;
    data_t r_data_q;
    resp_t r_resp_q;

    assign advance  = !r_valid_q || axi.rready;
    assign ar_ready = !s1_valid || advance;

    // stage 1 tracks the RAM access issued by the most recent AR
    always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
        if (!axi.aresetn) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
        end else if (ar_hs) begin
            s1_valid <= 1'b1;
            s1_err   <= !rd_ok;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // R register takes stage 1 whenever the current beat is gone or leaving
    always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
        if (!axi.aresetn) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
        end else if (advance) begin
            r_valid_q <= s1_valid;
            if (s1_valid) begin
                r_data_q <= s1_err ? '0 : ram_q;
                r_resp_q <= s1_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign axi.rvalid = r_valid_q;
    assign axi.rdata  = r_data_q;
    assign axi.rresp  = r_resp_q;
`else
    logic r_valid_q, r_err;

    assign ar_ready = !r_valid_q || axi.rready;

    // single beat in flight; RAM q holds because it only reloads on AR
    always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
        if (!axi.aresetn) begin
            r_valid_q <= 1'b0;
            r_err     <= 1'b0;
        end else if (ar_hs) begin
            r_valid_q <= 1'b1;
            r_err     <= !rd_ok;
        end else if (axi.rready) begin
            r_valid_q <= 1'b0;
        end
    end

    assign axi.rvalid = r_valid_q;
    assign axi.rdata  = r_err ? '0 : ram_q;
    assign axi.rresp  = r_err ? RESP_SLVERR : RESP_OKAY;
`endif
endmodule

// File: doc/axi4l_sramx32.md
# axi4l_sramx32

Parametrised AXI4-Lite single-port-per-channel 32-bit SRAM slave. Next generation of the SoC's on-chip data/instruction RAM: configurable depth, independent AW/W acceptance with buffering, proper B/R back-pressure, full-throughput reads and SLVERR on out-of-range addresses. Sits on the AXI4-Lite interconnect as a leaf slave and wraps the `dpramx32` macro, one write port and one read port.

## Interface
- `size`, default `'h1000`: RAM size in bytes. Power of two, ≥ 8. Word address width is `$clog2(size)-2`.
- `axi.aclk`, input, 1: clock. All logic is rising-edge.
- `axi.aresetn`, input, 1: one clock; reset is asynchronous and active-low.
- `axi`, `axi4l_if.slave`, 32-bit addr (`addr_t`) / 32-bit data: AW, W, B, AR and R channels. `resp` codes come from `axi4l_pkg`.

## Operation
- **AW buffer:** one entry. `awready = !aw_full`. An AW handshake stores `awaddr` and sets `aw_full`.
- **W buffer:** one entry. `wready = !w_full`. A W handshake stores `wdata` and `wstrb` and sets `w_full`.
- **Write commit:** occurs in the cycle where an address and data are both available, from buffer or same-cycle handshake, and the B slot is free (`!bvalid || bready`).
  - Commit clears the consumed buffers and sets `bvalid` on the next edge.
  - AW and W may arrive in either order or together. A same-cycle AW+W with a free B slot commits without buffering.
- **Range check:** `awaddr[31:$clog2(size)]` nonzero gives `bresp = SLVERR` and the RAM is not written. Otherwise `bresp = OKAY` and `ram_we = wstrb`. `awaddr[1:0]` is ignored.
- **B channel:** `bvalid` is held until `bready`. `bresp` is stable while `bvalid`.
- **Read:** `arready` depends on the configuration (see Configuration).
  - AR handshake drives `ram_raddr = araddr` word bits.
  - `rresp = SLVERR` with `rdata = 0` if the address is out of range, else `OKAY`.
  - `rdata` and `rresp` are stable while `rvalid && !rready`. The RAM read port is enabled only on AR handshake, so output holds.
- **Collision:** a read and a write commit to the same word in the same cycle return the old data (read-first).
- **Independence:** read and write channels are independent and have no ordering between them.
- **Reset mid-operation:** all buffers are emptied and `bvalid`/`rvalid` clear immediately. In-flight transactions are dropped. RAM contents are preserved.

## Timing
- **Reset values:**
  - `awready` = 1, `wready` = 1, `arready` = 1.
  - `bvalid` = 0, `rvalid` = 0.
  - `bresp` = OKAY, `rresp` = OKAY.
  - `rdata` is don't-care until the first R beat.
- **Write latency:** AW+W together with B free give `bvalid` one cycle later. Back-to-back writes with `bready` held at 1 sustain one write per cycle.
- **Write stall:** with `bvalid && !bready`, at most one further AW and one further W are accepted, then `awready`/`wready` drop to 0.
- **Read latency:** 1 cycle (AR handshake at edge N, `rvalid` after N), or 2 cycles with the output register.
- **Read throughput:** one read per cycle while `rready` = 1.

## Configuration
- **`AXI4L_SRAM_OUTREG_EN` defined:** a second read stage registers RAM output into an R register.
  - Read latency is 2 cycles.
  - Stage-1 data advances when `!rvalid || rready`.
  - `arready = !s1_valid || !rvalid || rready`.
  - Full throughput is kept, and up to two reads are in flight.
- **Not defined:** `rdata` comes directly from the RAM q.
  - Read latency is 1 cycle.
  - `arready = !rvalid || rready`.
  - At most one read is in flight.

## Test plan
- **Write-then-read:** AW+W same cycle with `awaddr = 0x10`, `wdata = 0xDEADBEEF`, `wstrb = 0xF`, then AR `0x10` → `bresp` OKAY one cycle later; `rdata = 0xDEADBEEF`, `rresp` OKAY after 1 cycle (2 cycles with `AXI4L_SRAM_OUTREG_EN`).
- **Split and partial write:**
  - W `0x11223344`/`wstrb = 0x5` three cycles before AW `0x20`, on a word preloaded with `0xAABBCCDD`.
  - Required: `wready` drops after the first W; one B beat after AW.
  - Read of `0x20` returns `0xAA22CC44`.
- **B back-pressure:** `bready = 0` for 5 cycles while issuing 3 writes → first write commits; `awready`/`wready` go to 0 after the second AW/W are buffered; the third is accepted only after `bready` rises; exactly 3 B beats, all OKAY.
- **Out of range** (`size = 'h1000`):
  - Write to `0x1004` with `wdata = 0x55` → `bresp = SLVERR`; word 1 keeps its prior value.
  - Read `0x1004` → `rresp = SLVERR`, `rdata = 0`.
- **Read stream with R stall:** AR `0x0`, `0x4`, `0x8` back-to-back, with `rready` low for 3 cycles after the first `rvalid` → `rdata` held at word 0 while stalled, then words 0, 1, 2 delivered in order, no duplicates or drops.
- **Reset and collision:**
  - Assert `aresetn = 0` with a buffered W and a pending R → `bvalid`/`rvalid` = 0 at once; readies = 1 after release; RAM data intact.
  - Same-cycle commit of `0x1` and read to the same word → the read returns the old value.
